// File: rtl/axi_pkg.sv
// Shared AXI4-Lite response codes and the slave's state encoding.
`timescale 1ns/1ps
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_RESP,
        WR_COLLECT,
        WR_WAIT,
        WR_RESP
    } state_t;

endpackage

// File: rtl/sram_bytewrite.sv
// Word array with per-byte write enables and a registered read port.
// The read register only updates when re is high, so it holds its value
// for as long as the caller needs it.
`timescale 1ns/1ps
module sram_bytewrite #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 12
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                re,
    input  logic [IDX_W-1:0]    raddr,
    output logic [DATA_W-1:0]   rdata,
    input  logic                we,
    input  logic [IDX_W-1:0]    waddr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb
);

    logic [DATA_W-1:0] mem [2**IDX_W];

    // Registered read, sampled only on request.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)   rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

    // Byte-masked write; contents are never cleared.
    always_ff @(posedge clock) begin
        if (we) begin
            for (int i = 0; i < DATA_W/8; i++) begin
                if (wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/axi_lite_sram_slave.sv
// AXI4-Lite memory responder: one transaction in flight, programmable
// response latency, byte-strobe writes, DECERR outside the window.
`timescale 1ns/1ps
module axi_lite_sram_slave
    import axi_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                DEPTH_LOG2 = 12,
    parameter logic [ADDR_W-1:0] BASE       = 32'h8000_0000,
    parameter int                LATENCY    = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic                arvalid,
    output logic                arready,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rvalid,
    input  logic                rready,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wvalid,
    output logic                wready,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready
);

    localparam logic [ADDR_W-1:0] WIN   = ADDR_W'(4) << DEPTH_LOG2;
    localparam int                CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    // The wait state is skipped when LATENCY=0, so it counts LATENCY-1 down
    // to zero; that gives LATENCY+1 cycles from handshake to valid.
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'((LATENCY > 0) ? LATENCY - 1 : 0);
    localparam state_t            RD_GO = (LATENCY == 0) ? RD_RESP : RD_WAIT;
    localparam state_t            WR_GO = (LATENCY == 0) ? WR_RESP : WR_WAIT;

    function automatic logic is_hit(input logic [ADDR_W-1:0] a);
        return (a - BASE) < WIN;
    endfunction

    function automatic logic [DEPTH_LOG2-1:0] word_idx(input logic [ADDR_W-1:0] a);
        return DEPTH_LOG2'((a - BASE) >> 2);
    endfunction

    state_t                state, state_n;
    logic [CNT_W-1:0]      cnt, cnt_n;
    logic                  aw_got, w_got, rd_hit_q;
    logic [ADDR_W-1:0]     awaddr_q, wa;
    logic [DATA_W-1:0]     wdata_q, wd, mem_q;
    logic [DATA_W/8-1:0]   wstrb_q, ws;
    logic                  ar_fire, aw_fire, w_fire, wr_enter;

    assign ar_fire  = arvalid & arready;
    assign aw_fire  = awvalid & awready;
    assign w_fire   = wvalid & wready;
    // Live channel values are used when the beat arrives on the same edge
    // as the commit (LATENCY=0).
    assign wa       = aw_fire ? awaddr : awaddr_q;
    assign wd       = w_fire  ? wdata  : wdata_q;
    assign ws       = w_fire  ? wstrb  : wstrb_q;
    assign wr_enter = (state_n == WR_RESP) && (state != WR_RESP);
    assign rvalid   = (state == RD_RESP);
    assign bvalid   = (state == WR_RESP);
    assign rdata    = rd_hit_q ? mem_q : '0;

    // Channel readiness per state; reads take priority in IDLE.
    always_comb begin
        arready = 1'b0;
        awready = 1'b0;
        wready  = 1'b0;
        case (state)
            IDLE: begin
                arready = 1'b1;
                awready = !arvalid;
                wready  = !arvalid;
            end
            WR_COLLECT: begin
                awready = !aw_got;
                wready  = !w_got;
            end
            default: ;
        endcase
    end

    // Next-state and latency counter.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (arvalid) begin
                    state_n = RD_GO;
                    cnt_n   = CNT_LOAD;
                end else if (aw_fire && w_fire) begin
                    state_n = WR_GO;
                    cnt_n   = CNT_LOAD;
                end else if (aw_fire || w_fire) begin
                    state_n = WR_COLLECT;
                end
            end
            RD_WAIT: begin
                if (cnt == '0) state_n = RD_RESP;
                else           cnt_n   = cnt - 1'b1;
            end
            RD_RESP: if (rready) state_n = IDLE;
            WR_COLLECT: begin
                if (aw_fire || w_fire) begin
                    state_n = WR_GO;
                    cnt_n   = CNT_LOAD;
                end
            end
            WR_WAIT: begin
                if (cnt == '0) state_n = WR_RESP;
                else           cnt_n   = cnt - 1'b1;
            end
            WR_RESP: if (bready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State, captured request fields and response codes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            aw_got   <= 1'b0;
            w_got    <= 1'b0;
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            rd_hit_q <= 1'b0;
            rresp    <= RESP_OKAY;
            bresp    <= RESP_OKAY;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (state == IDLE) begin
                aw_got <= aw_fire;
                w_got  <= w_fire;
            end else if (state == WR_COLLECT) begin
                aw_got <= aw_got | aw_fire;
                w_got  <= w_got | w_fire;
            end
            if (aw_fire) awaddr_q <= awaddr;
            if (w_fire) begin
                wdata_q <= wdata;
                wstrb_q <= wstrb;
            end
            if (ar_fire) begin
                rd_hit_q <= is_hit(araddr);
                rresp    <= is_hit(araddr) ? RESP_OKAY : RESP_DECERR;
            end
            if (wr_enter) bresp <= is_hit(wa) ? RESP_OKAY : RESP_DECERR;
        end
    end

    sram_bytewrite #(.DATA_W(DATA_W), .IDX_W(DEPTH_LOG2)) u_mem (
        .clock (clock),
        .reset (reset),
        .re    (ar_fire),
        .raddr (word_idx(araddr)),
        .rdata (mem_q),
        .we    (wr_enter && is_hit(wa)),
        .waddr (word_idx(wa)),
        .wdata (wd),
        .wstrb (ws)
    );

endmodule

// File: tb/tb_axi_lite_sram_slave.sv
// Directed bench with scoreboard queues: stimulus pushes expected
// responses, a monitor pops and checks them as the slave presents them.
`timescale 1ns/1ps
module tb_axi_lite_sram_slave;
    import axi_pkg::*;

    localparam int LAT = 2;

    logic        clock = 1'b0, reset = 1'b1;
    logic [31:0] araddr = '0, awaddr = '0, wdata = '0, rdata;
    logic        arvalid = 1'b0, awvalid = 1'b0, wvalid = 1'b0;
    logic        rready = 1'b1, bready = 1'b1;
    logic [3:0]  wstrb = '0;
    logic        arready, awready, wready, rvalid, bvalid;
    logic [1:0]  rresp, bresp;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        int          hs;
    } exp_t;

    exp_t rq[$];
    exp_t bq[$];
    int   n_cmp = 0, n_err = 0, cyc = 0;
    int   rh, wh, hs_dummy;
    bit   r_seen = 1'b0, b_seen = 1'b0;

    axi_lite_sram_slave #(.LATENCY(LAT)) dut (
        .clock(clock), .reset(reset),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] r, output int hs);
        int   n = 0;
        exp_t e;
        hs = -1;
        @(negedge clock);
        araddr = a; arvalid = 1'b1; #1;
        while (!arready) begin
            @(negedge clock); #1;
            if (++n > 200) begin
                chk("ar_timeout", 32'd0, 32'd1);
                arvalid = 1'b0;
                return;
            end
        end
        hs = cyc; e.data = d; e.resp = r; e.hs = hs;
        rq.push_back(e);
        @(posedge clock); #1;
        arvalid = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [1:0] r, input int wdly, output int hs);
        int   n = 0;
        exp_t e;
        hs = -1;
        @(negedge clock);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = (wdly == 0); #1;
        while (!(awready && (!wvalid || wready))) begin
            @(negedge clock); #1;
            if (++n > 200) begin
                chk("aw_timeout", 32'd0, 32'd1);
                awvalid = 1'b0; wvalid = 1'b0;
                return;
            end
        end
        if (wdly == 0) begin
            hs = cyc; e.data = '0; e.resp = r; e.hs = hs;
            bq.push_back(e);
        end
        @(posedge clock); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        if (wdly > 0) begin
            for (int i = 1; i <= wdly; i++) begin
                @(negedge clock);
                if (i == wdly) wvalid = 1'b1;
                #1;
                chk("split_wready", wready, 1);
                chk("split_awready", awready, 0);
            end
            hs = cyc; e.data = '0; e.resp = r; e.hs = hs;
            bq.push_back(e);
            @(posedge clock); #1;
            wvalid = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((rq.size() != 0 || bq.size() != 0) && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("drain_rq", rq.size(), 0);
        chk("drain_bq", bq.size(), 0);
        @(negedge clock);
    endtask

    // Monitor: checks latency at first valid, data every valid cycle,
    // pops on handshake.
    initial begin
        forever begin
            @(negedge clock); #2;
            if (rvalid) begin
                if (rq.size() == 0) chk("r_unexpected", rvalid, 0);
                else begin
                    if (!r_seen) begin
                        r_seen = 1'b1;
                        chk("r_latency", cyc - rq[0].hs, LAT + 1);
                    end
                    chk("rdata", rdata, rq[0].data);
                    chk("rresp", rresp, rq[0].resp);
                    if (rready) begin
                        void'(rq.pop_front());
                        r_seen = 1'b0;
                    end
                end
            end
            if (bvalid) begin
                if (bq.size() == 0) chk("b_unexpected", bvalid, 0);
                else begin
                    if (!b_seen) begin
                        b_seen = 1'b1;
                        chk("b_latency", cyc - bq[0].hs, LAT + 1);
                    end
                    chk("bresp", bresp, bq[0].resp);
                    if (bready) begin
                        void'(bq.pop_front());
                        b_seen = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clock);
        #1;
        chk("rst_arready", arready, 1);
        chk("rst_awready", awready, 1);
        chk("rst_wready", wready, 1);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_rresp", rresp, 0);
        chk("rst_bresp", bresp, 0);
        @(negedge clock);
        reset = 1'b0;

        // Full write then read back, sub-word address bits ignored
        do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, RESP_OKAY, 0, hs_dummy);
        do_read (32'h8000_0010, 32'hDEAD_BEEF, RESP_OKAY, hs_dummy);
        do_read (32'h8000_0013, 32'hDEAD_BEEF, RESP_OKAY, hs_dummy);

        // Partial strobe
        do_write(32'h8000_0020, 32'h1122_3344, 4'hF, RESP_OKAY, 0, hs_dummy);
        do_write(32'h8000_0020, 32'hAABB_CCDD, 4'b0101, RESP_OKAY, 0, hs_dummy);
        do_read (32'h8000_0020, 32'h11BB_33DD, RESP_OKAY, hs_dummy);

        // Split write: W four cycles after AW
        drain();
        do_write(32'h8000_0030, 32'hCAFE_F00D, 4'hF, RESP_OKAY, 4, hs_dummy);
        do_read (32'h8000_0030, 32'hCAFE_F00D, RESP_OKAY, hs_dummy);

        // Read/write collision with read backpressure
        drain();
        rready = 1'b0;
        fork
            do_read (32'h8000_0010, 32'hDEAD_BEEF, RESP_OKAY, rh);
            do_write(32'h8000_0040, 32'h0102_0304, 4'hF, RESP_OKAY, 0, wh);
            begin
                repeat (LAT + 1 + 5 + 1) @(negedge clock);
                rready = 1'b1;
            end
        join
        chk("read_first", (wh > rh) ? 32'd1 : 32'd0, 1);
        do_read (32'h8000_0040, 32'h0102_0304, RESP_OKAY, hs_dummy);

        // Window boundaries and DECERR
        do_read (32'h0000_1000, 32'h0, RESP_DECERR, hs_dummy);
        do_write(32'h8000_0000, 32'h55AA_55AA, 4'hF, RESP_OKAY, 0, hs_dummy);
        do_write(32'h9000_0000, 32'hFFFF_FFFF, 4'hF, RESP_DECERR, 0, hs_dummy);
        do_read (32'h8000_0000, 32'h55AA_55AA, RESP_OKAY, hs_dummy);
        do_write(32'h8000_3FFC, 32'h0BAD_CAFE, 4'hF, RESP_OKAY, 0, hs_dummy);
        do_read (32'h8000_3FFC, 32'h0BAD_CAFE, RESP_OKAY, hs_dummy);
        do_read (32'h8000_4000, 32'h0, RESP_DECERR, hs_dummy);
        do_read (32'h7FFF_FFFC, 32'h0, RESP_DECERR, hs_dummy);

        // Reset while a read waits for its latency
        drain();
        @(negedge clock);
        araddr = 32'h8000_0020; arvalid = 1'b1; #1;
        @(posedge clock); #1;
        arvalid = 1'b0;
        @(negedge clock); #1;
        reset = 1'b1; #1;
        chk("midrst_rvalid", rvalid, 0);
        chk("midrst_arready", arready, 1);
        @(negedge clock);
        reset = 1'b0;
        do_read (32'h8000_0020, 32'h11BB_33DD, RESP_OKAY, hs_dummy);
        do_read (32'h8000_0010, 32'hDEAD_BEEF, RESP_OKAY, hs_dummy);

        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
